dram_readback_ctrl: RTL

//  Read side of the channel-sample DRAM store. On a request, fetches one board's stored rounds (ts word +

---
 rtl/dram_readback_ctrl_pkg.sv | 30 +++
 rtl/dram_readback_ctrl_if.sv | 19 +
 rtl/dram_readback_ctrl_fifo.sv | 57 +++++
 rtl/dram_readback_ctrl.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/dram_readback_ctrl_pkg.sv
// Shared definitions for the channel-sample DRAM store.
// Holds the address map (field widths/positions), store geometry, the
// readback FSM state type and the address pack function. The write address
// generator imports the same package so both sides agree on the layout.
package dram_readback_ctrl_pkg;
  localparam int CHANNELS_PER_ROUND = 125;  // channel 0 is the timestamp word
  localparam int CHANNEL_OFFSET_LEN = 14;
  localparam int NUM_BOARDS         = 8;
  localparam int BOARD_W            = 3;
  localparam int CHAN_W             = 7;
  localparam int DATA_W             = 256;
  localparam int FIFO_DEPTH         = 16;
  localparam int ADDR_W             = 25;
  localparam int BURST_W            = 5;

  // Address layout: [24]=0, [23:21]=board, [20:14]=channel, [13:0]=offset
  localparam int ADDR_OFF_LSB   = 0;
  localparam int ADDR_CH_LSB    = ADDR_OFF_LSB + CHANNEL_OFFSET_LEN;
  localparam int ADDR_BOARD_LSB = ADDR_CH_LSB + CHAN_W;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN} rb_state_e;

  function automatic logic [ADDR_W-1:0] pack_addr(
    input logic [BOARD_W-1:0]            board,
    input logic [CHAN_W-1:0]             chan,
    input logic [CHANNEL_OFFSET_LEN-1:0] offset
  );
    return {1'b0, board, chan, offset};
  endfunction
endpackage

// File: rtl/dram_readback_ctrl_if.sv
// Read side of the DRAM controller port.
//  read / burst_count / addr : command, driven by the readback controller
//  wait_request              : high = controller takes the command this cycle
//  rd_valid / rd_data        : in-order read return
interface dram_readback_ctrl_if;
  import dram_readback_ctrl_pkg::*;

  logic                 read;
  logic [BURST_W-1:0]   burst_count;
  logic [ADDR_W-1:0]    addr;
  logic                 wait_request;
  logic                 rd_valid;
  logic [DATA_W-1:0]    rd_data;

  modport master (output read, burst_count, addr,
                  input  wait_request, rd_valid, rd_data);
  modport slave  (input  read, burst_count, addr,
                  output wait_request, rd_valid, rd_data);
endinterface

// File: rtl/dram_readback_ctrl_fifo.sv
// readback_fifo: synchronous show-ahead FIFO for DRAM return data.
//  i_push/i_wdata : write side (never back-pressured; caller guarantees room)
//  i_pop          : read side; ignored while empty
//  o_rdata        : head word, valid whenever !o_empty
//  o_empty/o_count: occupancy, o_count runs 0..DEPTH
// DEPTH must be a power of 2 so the pointers wrap naturally.
module readback_fifo
  import dram_readback_ctrl_pkg::*;
#(
  parameter  int W     = DATA_W,
  parameter  int DEPTH = FIFO_DEPTH,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push,
  input  logic [W-1:0] i_wdata,
  input  logic         i_pop,
  output logic [W-1:0] o_rdata,
  output logic         o_empty,
  output logic [AW:0]  o_count
);
  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [AW:0]   r_count;
  logic          w_pop;

  assign o_empty = (r_count == '0);
  assign w_pop   = i_pop & ~o_empty;
  assign o_rdata = r_mem[r_rp];
  assign o_count = r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_wp <= r_wp + AW'(1);
      if (w_pop)  r_rp <= r_rp + AW'(1);
      case ({i_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: ;
      endcase
    end
  end

  // Storage needs no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wp] <= i_wdata;
  end

  // A push while full is only legal when the head leaves the same cycle.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(i_push && !w_pop && r_count == (AW+1)'(DEPTH)));
endmodule

// File: rtl/dram_readback_ctrl.sv
// dram_readback_ctrl: reads one board's stored rounds back from DRAM.
//  clk, rst            : single clock, synchronous active-high reset
//  i_req_*/o_req_ready : request {board, start offset, number of offsets}
//  i_channel_offsets   : write-side next offset per board (board b at [14b+13:14b])
//  dram                : read command / return port (burst-1 reads)
//  o_out_*/i_out_ready : output word stream tagged {board, channel, offset}
//  o_busy, o_done, o_req_error : status; done/error are one-cycle pulses
// Reads are issued channel-inner, offset-outer. Outstanding reads plus FIFO
// occupancy never exceed FIFO_DEPTH, so every return has a slot waiting.
module dram_readback_ctrl
  import dram_readback_ctrl_pkg::*;
(
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   i_req_valid,
  output logic                                   o_req_ready,
  input  logic [BOARD_W-1:0]                     i_req_board,
  input  logic [CHANNEL_OFFSET_LEN-1:0]          i_req_start_offset,
  input  logic [CHANNEL_OFFSET_LEN-1:0]          i_req_num_offsets,
  input  logic [NUM_BOARDS*CHANNEL_OFFSET_LEN-1:0] i_channel_offsets,
  dram_readback_ctrl_if.master                   dram,
  output logic                                   o_out_valid,
  input  logic                                   i_out_ready,
  output logic [DATA_W-1:0]                      o_out_data,
  output logic [BOARD_W-1:0]                     o_out_board,
  output logic [CHAN_W-1:0]                      o_out_channel,
  output logic [CHANNEL_OFFSET_LEN-1:0]          o_out_offset,
  output logic                                   o_out_last,
  output logic                                   o_busy,
  output logic                                   o_done,
  output logic                                   o_req_error
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CHAN_W-1:0] LAST_CH = CHAN_W'(CHANNELS_PER_ROUND - 1);
  typedef logic [CHANNEL_OFFSET_LEN-1:0] off_t;

  rb_state_e          r_state, w_state_nxt;
  logic [BOARD_W-1:0] r_board;
  logic [CHAN_W-1:0]  r_iss_ch, r_out_ch;
  off_t               r_iss_off, r_out_off, r_iss_rem, r_out_rem;
  logic [CW-1:0]      r_in_flight;
  logic               r_done, r_req_error;

  logic [NUM_BOARDS-1:0][CHANNEL_OFFSET_LEN-1:0] w_wr_off;
  off_t          w_avail;
  logic          w_idle, w_take, w_reject, w_start, w_empty_req;
  logic          w_credit, w_cmd, w_cmd_acc, w_iss_last;
  logic          w_pop, w_out_last, w_fifo_empty;
  logic [CW-1:0] w_fifo_count;
  logic [DATA_W-1:0] w_fifo_rdata;

  // Offsets available to read: distance from start up to the writer, mod 2^14.
  assign w_wr_off    = i_channel_offsets;
  assign w_avail     = w_wr_off[i_req_board] - i_req_start_offset;
  assign w_idle      = (r_state == S_IDLE);
  assign w_take      = w_idle & i_req_valid;
  assign w_reject    = w_take & (i_req_num_offsets > w_avail);
  assign w_empty_req = w_take & (i_req_num_offsets == '0);
  assign w_start     = w_take & ~w_reject & (i_req_num_offsets != '0);

  assign w_credit   = ({1'b0, r_in_flight} + {1'b0, w_fifo_count}) < (CW+1)'(FIFO_DEPTH);
  assign w_cmd      = (r_state == S_ISSUE) & w_credit;
  assign w_cmd_acc  = w_cmd & dram.wait_request;
  assign w_iss_last = (r_iss_ch == LAST_CH) && (r_iss_rem == off_t'(1));
  assign w_pop      = o_out_valid & i_out_ready;
  assign w_out_last = (r_out_ch == LAST_CH) && (r_out_rem == off_t'(1));

  assign o_req_ready      = w_idle;
  assign o_busy           = ~w_idle;
  assign o_done           = r_done;
  assign o_req_error      = r_req_error;
  assign dram.read        = w_cmd;
  assign dram.burst_count = w_cmd ? BURST_W'(1) : '0;
  assign dram.addr        = pack_addr(r_board, r_iss_ch, r_iss_off);
  assign o_out_valid      = ~w_fifo_empty;
  assign o_out_data       = o_out_valid ? w_fifo_rdata : '0;
  assign o_out_board      = r_board;
  assign o_out_channel    = r_out_ch;
  assign o_out_offset     = r_out_off;
  assign o_out_last       = o_out_valid & w_out_last;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_start)                w_state_nxt = S_ISSUE;
      S_ISSUE: if (w_cmd_acc & w_iss_last) w_state_nxt = S_DRAIN;
      S_DRAIN: if (w_pop & w_out_last)     w_state_nxt = S_IDLE;
      default:                             w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_board     <= '0;
      r_iss_ch    <= '0;
      r_out_ch    <= '0;
      r_iss_off   <= '0;
      r_out_off   <= '0;
      r_iss_rem   <= '0;
      r_out_rem   <= '0;
      r_in_flight <= '0;
      r_done      <= 1'b0;
      r_req_error <= 1'b0;
    end else begin
      r_done      <= w_empty_req | (w_pop & w_out_last);
      r_req_error <= w_reject;
      // Issue-side walk; tags on the output side replay the same walk
      // because returns come back in command order.
      if (w_cmd_acc) begin
        if (r_iss_ch == LAST_CH) begin
          r_iss_ch  <= '0;
          r_iss_off <= r_iss_off + off_t'(1);
          r_iss_rem <= r_iss_rem - off_t'(1);
        end else begin
          r_iss_ch  <= r_iss_ch + CHAN_W'(1);
        end
      end
      if (w_pop) begin
        if (r_out_ch == LAST_CH) begin
          r_out_ch  <= '0;
          r_out_off <= r_out_off + off_t'(1);
          r_out_rem <= r_out_rem - off_t'(1);
        end else begin
          r_out_ch  <= r_out_ch + CHAN_W'(1);
        end
      end
      if (w_start) begin
        r_board   <= i_req_board;
        r_iss_ch  <= '0;
        r_out_ch  <= '0;
        r_iss_off <= i_req_start_offset;
        r_out_off <= i_req_start_offset;
        r_iss_rem <= i_req_num_offsets;
        r_out_rem <= i_req_num_offsets;
      end
      case ({w_cmd_acc, dram.rd_valid})
        2'b10:   r_in_flight <= r_in_flight + CW'(1);
        2'b01:   r_in_flight <= r_in_flight - CW'(1);
        default: ;
      endcase
    end
  end

  readback_fifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (dram.rd_valid),
    .i_wdata (dram.rd_data),
    .i_pop   (w_pop),
    .o_rdata (w_fifo_rdata),
    .o_empty (w_fifo_empty),
    .o_count (w_fifo_count)
  );
endmodule
